// File: rtl/spdif_rx_lock_ctrl_pkg.sv
// Shared constants for the S/PDIF receive lock controller: preamble codes, subframe
// bit positions, block geometry and the lock state encoding.
package spdif_pkg;

  localparam logic [1:0] SYNC_ERR = 2'd0;
  localparam logic [1:0] SYNC_B   = 2'd1;
  localparam logic [1:0] SYNC_M   = 2'd2;
  localparam logic [1:0] SYNC_W   = 2'd3;

  localparam int FRAMES_PER_BLOCK = 192;
  localparam int CS_BITS          = 32;

  localparam int AUD_MSB = 23;
  localparam int V_BIT   = 24;
  localparam int U_BIT   = 25;
  localparam int C_BIT   = 26;
  localparam int P_BIT   = 27;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_SEEK     = 2'd1,
    ST_LOCKED   = 2'd2
  } lock_state_e;

  // Frame index that the next left subframe will carry, wrapping at the block end.
  function automatic logic [7:0] next_frame_idx(input logic [7:0] idx);
    return (idx == 8'(FRAMES_PER_BLOCK - 1)) ? 8'd0 : idx + 8'd1;
  endfunction

endpackage

// File: rtl/spdif_rx_lock_ctrl_cs_capture.sv
// Tracks the frame index within a 192-frame block and collects channel-status bits
// 0..31; publishes them only when the whole block so far was received while locked.
module spdif_cs_capture
  import spdif_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        left_stb_i,
  input  logic        is_b_i,
  input  logic        wr_c_i,
  input  logic        c_bit_i,
  input  logic        block_ok_i,
  input  logic        clear_i,
  output logic [7:0]  frame_idx_o,
  output logic [31:0] cs_word_o,
  output logic        cs_valid_o
);

  logic [7:0]  frame_idx_q, frame_idx_d, idx_new;
  logic [31:0] shadow_q, shadow_d;
  logic [31:0] cs_word_q, cs_word_d;
  logic        cs_valid_q, cs_valid_d;
  logic        in_cs_window;

  always_comb begin
    idx_new      = is_b_i ? 8'd0 : next_frame_idx(frame_idx_q);
    in_cs_window = idx_new < 8'(CS_BITS);
    frame_idx_d  = left_stb_i ? idx_new : frame_idx_q;
    shadow_d     = shadow_q;
    cs_word_d    = cs_word_q;
    cs_valid_d   = 1'b0;
    if (clear_i) begin
      shadow_d = '0;
    end else if (left_stb_i && wr_c_i && in_cs_window) begin
      // Bits are placed by frame index so a dropped frame cannot skew later bits.
      shadow_d[idx_new[4:0]] = c_bit_i;
      if (block_ok_i && (idx_new == 8'(CS_BITS - 1))) begin
        cs_word_d  = shadow_d;
        cs_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_idx_q <= '0;
      shadow_q    <= '0;
      cs_word_q   <= '0;
      cs_valid_q  <= 1'b0;
    end else begin
      frame_idx_q <= frame_idx_d;
      shadow_q    <= shadow_d;
      cs_word_q   <= cs_word_d;
      cs_valid_q  <= cs_valid_d;
    end
  end

  assign frame_idx_o = frame_idx_q;
  assign cs_word_o   = cs_word_q;
  assign cs_valid_o  = cs_valid_q;

endmodule

// File: rtl/spdif_rx_lock_ctrl.sv
// Lock/sequence controller behind the S/PDIF subframe decoder: checks preamble order and
// block alignment, decides lock and mute, and measures the frame period.
module spdif_rx_lock_ctrl
  import spdif_pkg::*;
#(
  parameter int LOCK_FRAMES = 4,
  parameter int ERR_LIMIT   = 8,
  parameter int TIMEOUT_CYC = 4095,
  parameter int PER_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sf_valid,
  input  logic [1:0]       sf_sync,
  input  logic             sf_parity_ok,
  input  logic [27:0]      sf_data,
  output logic             locked,
  output logic             mute,
  output logic             block_start,
  output logic [31:0]      cs_word,
  output logic             cs_valid,
  output logic [PER_W-1:0] frame_period,
  output logic [7:0]       err_count
);

  localparam int GF_W = $clog2(LOCK_FRAMES + 1);
  localparam int BR_W = $clog2(ERR_LIMIT + 1);
  localparam int ID_W = $clog2(TIMEOUT_CYC + 1);

  lock_state_e      state_q, state_d;
  logic [GF_W-1:0]  good_frames_q, good_frames_d;
  logic [BR_W-1:0]  bad_run_q, bad_run_d;
  logic [ID_W-1:0]  idle_q, idle_d;
  logic [PER_W-1:0] per_cnt_q, per_cnt_d;
  logic [PER_W-1:0] frame_period_q, frame_period_d;
  logic [7:0]       err_count_q, err_count_d;
  logic             expect_w_q, expect_w_d;
  logic             block_ok_q, block_ok_d;
  logic             locked_q, locked_d;
  logic             mute_q, mute_d;
  logic             block_start_q, block_start_d;

  logic       is_b, is_m, is_w, is_left;
  logic       ord_ok, good, bad, pos_break, timeout;
  logic [7:0] frame_idx, nidx;
  logic       left_stb, wr_c, good_left, leave_locked;
  logic       unused_data;

  // Only the C bit matters here; audio, V, U and P pass straight to the sink.
  assign unused_data = ^{sf_data[P_BIT], sf_data[U_BIT], sf_data[V_BIT], sf_data[AUD_MSB:0]};

  always_comb begin
    is_b      = (sf_sync == SYNC_B);
    is_m      = (sf_sync == SYNC_M);
    is_w      = (sf_sync == SYNC_W);
    is_left   = is_b || is_m;
    nidx      = next_frame_idx(frame_idx);
    ord_ok    = 1'b0;
    if (is_w)      ord_ok = expect_w_q;
    else if (is_b) ord_ok = !expect_w_q && (nidx == 8'd0);
    else if (is_m) ord_ok = !expect_w_q && (nidx != 8'd0);
    good      = sf_valid && sf_parity_ok && ord_ok;
    bad       = sf_valid && !good;
    pos_break = sf_valid && ((is_b && (nidx != 8'd0)) || (is_m && (nidx == 8'd0)));
    timeout   = !sf_valid && (idle_q == ID_W'(TIMEOUT_CYC));
  end

  always_comb begin
    state_d       = state_q;
    good_frames_d = good_frames_q;
    bad_run_d     = bad_run_q;
    err_count_d   = err_count_q;
    expect_w_d    = expect_w_q;
    block_ok_d    = block_ok_q;
    block_start_d = 1'b0;
    left_stb      = 1'b0;
    wr_c          = 1'b0;
    good_left     = 1'b0;
    leave_locked  = 1'b0;
    case (state_q)
      ST_UNLOCKED: begin
        if (sf_valid && is_b && sf_parity_ok) begin
          state_d       = ST_SEEK;
          good_frames_d = '0;
          expect_w_d    = 1'b1;
          left_stb      = 1'b1;
          wr_c          = 1'b1;
          good_left     = 1'b1;
        end
      end
      ST_SEEK: begin
        if (good) begin
          if (is_w) begin
            expect_w_d    = 1'b0;
            good_frames_d = good_frames_q + GF_W'(1);
            if (good_frames_d == GF_W'(LOCK_FRAMES)) state_d = ST_LOCKED;
          end else begin
            expect_w_d = 1'b1;
            left_stb   = 1'b1;
            wr_c       = 1'b1;
            good_left  = 1'b1;
          end
        end else if (bad) begin
          state_d = ST_UNLOCKED;
        end
      end
      ST_LOCKED: begin
        if (sf_valid) begin
          // A valid preamble keeps the position even when parity fails, so one bad
          // subframe costs one error rather than a cascade of order errors.
          if (is_left) begin
            expect_w_d = 1'b1;
            left_stb   = 1'b1;
          end else if (is_w) begin
            expect_w_d = 1'b0;
          end
          if (good) begin
            bad_run_d = '0;
            if (is_left) begin
              wr_c      = 1'b1;
              good_left = 1'b1;
            end
            if (is_b) begin
              block_start_d = 1'b1;
              block_ok_d    = 1'b1;
            end
          end else begin
            if (bad_run_q != BR_W'(ERR_LIMIT)) bad_run_d = bad_run_q + BR_W'(1);
            if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
            if (bad_run_d == BR_W'(ERR_LIMIT)) state_d = ST_UNLOCKED;
          end
          if (pos_break) state_d = ST_UNLOCKED;
        end
      end
      default: state_d = ST_UNLOCKED;
    endcase
    if (timeout) state_d = ST_UNLOCKED;
    leave_locked = (state_q == ST_LOCKED) && (state_d != ST_LOCKED);
    if (leave_locked) begin
      bad_run_d     = '0;
      block_ok_d    = 1'b0;
      block_start_d = 1'b0;
    end
    locked_d = (state_d == ST_LOCKED);
    mute_d   = !locked_d || (bad_run_d != '0);
  end

  always_comb begin
    idle_d = '0;
    if (!sf_valid) idle_d = (idle_q == ID_W'(TIMEOUT_CYC)) ? idle_q : idle_q + ID_W'(1);
    per_cnt_d      = (per_cnt_q == '1) ? per_cnt_q : per_cnt_q + PER_W'(1);
    frame_period_d = frame_period_q;
    if (good_left) begin
      per_cnt_d      = PER_W'(1);
      frame_period_d = per_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_UNLOCKED;
      good_frames_q  <= '0;
      bad_run_q      <= '0;
      idle_q         <= '0;
      per_cnt_q      <= '0;
      frame_period_q <= '0;
      err_count_q    <= '0;
      expect_w_q     <= 1'b0;
      block_ok_q     <= 1'b0;
      locked_q       <= 1'b0;
      mute_q         <= 1'b1;
      block_start_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      good_frames_q  <= good_frames_d;
      bad_run_q      <= bad_run_d;
      idle_q         <= idle_d;
      per_cnt_q      <= per_cnt_d;
      frame_period_q <= frame_period_d;
      err_count_q    <= err_count_d;
      expect_w_q     <= expect_w_d;
      block_ok_q     <= block_ok_d;
      locked_q       <= locked_d;
      mute_q         <= mute_d;
      block_start_q  <= block_start_d;
    end
  end

  spdif_cs_capture u_cs_capture (
    .clk         (clk),
    .rst         (rst),
    .left_stb_i  (left_stb),
    .is_b_i      (is_b),
    .wr_c_i      (wr_c),
    .c_bit_i     (sf_data[C_BIT]),
    .block_ok_i  (block_ok_q),
    .clear_i     (leave_locked),
    .frame_idx_o (frame_idx),
    .cs_word_o   (cs_word),
    .cs_valid_o  (cs_valid)
  );

  assign locked       = locked_q;
  assign mute         = mute_q;
  assign block_start  = block_start_q;
  assign frame_period = frame_period_q;
  assign err_count    = err_count_q;

endmodule

// File: tb/tb_spdif_rx_lock_ctrl.sv
// Directed bench for spdif_rx_lock_ctrl: a vector table for lock/error behaviour plus
// hand-written sequences for block capture, alignment break, timeout and reset.
module tb_spdif_rx_lock_ctrl;
  import spdif_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        sf_valid;
  logic [1:0]  sf_sync;
  logic        sf_parity_ok;
  logic [27:0] sf_data;
  logic        locked, mute, block_start, cs_valid;
  logic [31:0] cs_word;
  logic [15:0] frame_period;
  logic [7:0]  err_count;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [1:0] sync;
    logic       par;
    logic       exp_locked;
    logic       exp_mute;
    logic [7:0] exp_err;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] cs_pat;

  spdif_rx_lock_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .sf_valid     (sf_valid),
    .sf_sync      (sf_sync),
    .sf_parity_ok (sf_parity_ok),
    .sf_data      (sf_data),
    .locked       (locked),
    .mute         (mute),
    .block_start  (block_start),
    .cs_word      (cs_word),
    .cs_valid     (cs_valid),
    .frame_period (frame_period),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  function automatic void add(input logic [1:0] s, input logic p, input logic l,
                              input logic m, input logic [7:0] e);
    vecs.push_back('{s, p, l, m, e});
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  // One-cycle strobe; returns just after the capturing edge so outputs are current.
  task automatic send(input logic [1:0] s, input logic p, input logic c);
    sf_valid     = 1'b1;
    sf_sync      = s;
    sf_parity_ok = p;
    sf_data      = {1'b0, c, 2'b00, 24'($urandom)};
    @(posedge clk);
    #1;
    sf_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    cs_pat = 32'h0200_0104;
    // Lock-up from reset: 4 good frames lock on the 4th W.
    add(SYNC_B, 1, 0, 1, 0);  add(SYNC_W, 1, 0, 1, 0);
    add(SYNC_M, 1, 0, 1, 0);  add(SYNC_W, 1, 0, 1, 0);
    add(SYNC_M, 1, 0, 1, 0);  add(SYNC_W, 1, 0, 1, 0);
    add(SYNC_M, 1, 0, 1, 0);  add(SYNC_W, 1, 1, 0, 0);
    add(SYNC_M, 1, 1, 0, 0);  add(SYNC_W, 1, 1, 0, 0);
    add(SYNC_M, 1, 1, 0, 0);  add(SYNC_W, 1, 1, 0, 0);
    // Seven parity errors keep lock with mute raised; one good subframe clears the run.
    for (int i = 0; i < 7; i++) add((i % 2 == 0) ? SYNC_M : SYNC_W, 0, 1, 1, 8'(i + 1));
    add(SYNC_W, 1, 1, 0, 7);
    // Eight in a row drop lock on the eighth.
    for (int i = 0; i < 7; i++) add((i % 2 == 0) ? SYNC_M : SYNC_W, 0, 1, 1, 8'(i + 8));
    add(SYNC_W, 0, 0, 1, 15);

    rst = 1'b1; sf_valid = 1'b0; sf_sync = SYNC_ERR; sf_parity_ok = 1'b0; sf_data = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset locked", locked, 0);
    chk("reset mute", mute, 1);
    chk("reset block_start", block_start, 0);
    chk("reset cs_word", cs_word, 0);
    chk("reset cs_valid", cs_valid, 0);
    chk("reset frame_period", frame_period, 0);
    chk("reset err_count", err_count, 0);

    foreach (vecs[i]) begin
      send(vecs[i].sync, vecs[i].par, 1'b0);
      chk($sformatf("vec%0d locked", i), locked, vecs[i].exp_locked);
      chk($sformatf("vec%0d mute", i), mute, vecs[i].exp_mute);
      chk($sformatf("vec%0d err_count", i), err_count, vecs[i].exp_err);
      chk($sformatf("vec%0d block_start", i), block_start, 0);
    end

    // Partial first block after lock must not publish channel status.
    send(SYNC_B, 1, cs_pat[0]);
    send(SYNC_W, 1, 0);
    for (int f = 1; f < 192; f++) begin
      send(SYNC_M, 1, (f < 32) ? cs_pat[f[4:0]] : 1'b0);
      if (f == 31) chk("partial block cs_valid", cs_valid, 0);
      send(SYNC_W, 1, 0);
      if (f == 3) chk("relock after 4 frames", locked, 1);
    end
    chk("frame_period back-to-back", frame_period, 2);

    // Full locked block: cs_word published at frame 31.
    send(SYNC_B, 1, cs_pat[0]);
    chk("block_start on B", block_start, 1);
    send(SYNC_W, 1, 0);
    chk("block_start one cycle", block_start, 0);
    for (int f = 1; f < 32; f++) begin
      send(SYNC_M, 1, cs_pat[f[4:0]]);
      if (f < 31) chk($sformatf("cs_valid idle f%0d", f), cs_valid, 0);
      send(SYNC_W, 1, 0);
    end
    // cs_valid pulsed on the frame-31 left; re-send check through a fresh pattern below.
    for (int f = 32; f < 57; f++) begin
      send(SYNC_M, 1, 0);
      send(SYNC_W, 1, 0);
    end
    chk("cs_word after block", cs_word, 32'h0200_0104);

    // Misplaced B at frame 57 breaks lock immediately.
    send(SYNC_B, 1, 0);
    chk("misplaced B locked", locked, 0);
    chk("misplaced B mute", mute, 1);
    chk("misplaced B block_start", block_start, 0);
    chk("cs_word holds", cs_word, 32'h0200_0104);

    // Period measurement with subframes 65 clk apart, then timeout.
    send(SYNC_B, 1, 0); idle(64);
    send(SYNC_W, 1, 0); idle(64);
    for (int f = 1; f < 4; f++) begin
      send(SYNC_M, 1, 0); idle(64);
      send(SYNC_W, 1, 0); idle(64);
    end
    chk("spaced lock", locked, 1);
    send(SYNC_M, 1, 0);
    chk("frame_period 130", frame_period, 130);
    idle(4095);
    send(SYNC_W, 1, 0);
    chk("sf_valid beats timeout", locked, 1);
    idle(4000);
    chk("locked before timeout", locked, 1);
    idle(100);
    chk("timeout unlock", locked, 0);
    chk("timeout mute", mute, 1);
    chk("frame_period holds", frame_period, 130);

    // Reset in SEEK, coinciding with a good strobe.
    send(SYNC_B, 1, 0); send(SYNC_W, 1, 0);
    send(SYNC_M, 1, 0); send(SYNC_W, 1, 0);
    rst = 1'b1;
    send(SYNC_M, 1, 1);
    rst = 1'b0;
    chk("rst locked", locked, 0);
    chk("rst mute", mute, 1);
    chk("rst block_start", block_start, 0);
    chk("rst cs_word", cs_word, 0);
    chk("rst cs_valid", cs_valid, 0);
    chk("rst frame_period", frame_period, 0);
    chk("rst err_count", err_count, 0);
    for (int f = 0; f < 5; f++) begin
      send(SYNC_M, 1, 0);
      send(SYNC_W, 1, 0);
    end
    chk("no lock without B", locked, 0);
    send(SYNC_B, 1, 0); send(SYNC_W, 1, 0);
    for (int f = 1; f < 4; f++) begin
      send(SYNC_M, 1, 0);
      send(SYNC_W, 1, 0);
    end
    chk("lock after fresh B", locked, 1);
    chk("mute after fresh lock", mute, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // cs_valid pulse watcher for the full locked block: exactly one pulse with the pattern.
  int cs_pulses = 0;
  always @(negedge clk) begin
    if (cs_valid === 1'b1) begin
      cs_pulses++;
      chk("cs_word at cs_valid", cs_word, 32'h0200_0104);
    end
  end

  final begin
    if (cs_pulses != 1) $display("FAIL cs_valid pulse count: got %0d, required 1", cs_pulses);
  end

endmodule
